// File: rtl/bp_pkg.sv
// Shared branch-predictor types: table geometry, counter encodings, FSM states, PC field helpers.
// Pure declarations; no latency and no flow control.
package bp_pkg;

    localparam int IDX_BITS    = 6;
    localparam int TAG_BITS    = 10;
    localparam int NUM_ENTRIES = 1 << IDX_BITS;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        IDLE,
        SWEEP
    } bp_state_e;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    function automatic idx_t pc_idx(input logic [31:0] pc);
        return pc[IDX_BITS+1:2];
    endfunction

    function automatic tag_t pc_tag(input logic [31:0] pc);
        return pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle of the branch predictor: lookup, training, flush and redirect signals.
// Master is the pipeline, slave is the predictor; ready low means the table is being swept.
interface branch_predictor_if;

    logic [31:0] lk_pc;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        lk_hit;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush;
    logic        ready;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    modport master (
        output lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush,
        input  lk_taken, lk_target, lk_hit, ready, mispredict, redirect_pc,
        input  stat_lookups, stat_updates, stat_mispredicts
    );
    modport slave (
        input  lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush,
        output lk_taken, lk_target, lk_hit, ready, mispredict, redirect_pc,
        output stat_lookups, stat_updates, stat_mispredicts
    );
`else
    modport master (
        output lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush,
        input  lk_taken, lk_target, lk_hit, ready, mispredict, redirect_pc
    );
    modport slave (
        input  lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush,
        output lk_taken, lk_target, lk_hit, ready, mispredict, redirect_pc
    );
`endif

endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-value logic.
// Combinational, zero latency; no flow control.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counters: zero-latency lookup, table trained at execute, mispredict/redirect registered (1 cycle).
// Flush sweeps every entry over 2^IDX_BITS cycles with ready low; BP_STATS_EN adds lookup/update/mispredict counters.
module branch_predictor
    import bp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predictor_if.slave    bus
);

    logic        valid_q [NUM_ENTRIES];
    logic [1:0]  ctr_q   [NUM_ENTRIES];
    tag_t        tag_q   [NUM_ENTRIES];
    logic [31:0] tgt_q   [NUM_ENTRIES];

    bp_state_e   state_q, state_d;
    idx_t        sweep_idx_q, sweep_idx_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_q, redirect_d;
    logic        ready;

    assign ready = (state_q == IDLE);

    // Lookup reads the registered table, so a same-cycle write is only seen next cycle.
    idx_t lk_idx;
    logic lk_hit;
    logic lk_taken;
    assign lk_idx   = pc_idx(bus.lk_pc);
    assign lk_hit   = ready && valid_q[lk_idx] && (tag_q[lk_idx] == pc_tag(bus.lk_pc));
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    assign bus.lk_hit      = lk_hit;
    assign bus.lk_taken    = lk_taken;
    assign bus.lk_target   = lk_taken ? tgt_q[lk_idx] : bus.lk_pc + 32'd4;
    assign bus.ready       = ready;
    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_q;

    idx_t       upd_idx;
    logic       upd_hit;
    logic       wr_en;
    logic [1:0] ctr_nxt;
    assign upd_idx = pc_idx(bus.upd_pc);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == pc_tag(bus.upd_pc));
    assign wr_en   = bus.upd_en && ready && !bus.flush;

    sat_counter2 u_ctr (
        .ctr_i (ctr_q[upd_idx]),
        .inc_i (bus.upd_taken),
        .ctr_o (ctr_nxt)
    );

    assign mispredict_d = bus.upd_en &&
                          ((bus.upd_taken != bus.upd_pred_taken) ||
                           (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));
    assign redirect_d   = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                end
            end
            SWEEP: begin
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == idx_t'(NUM_ENTRIES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sweep_idx_q  <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else if (state_q == SWEEP) begin
            valid_q[sweep_idx_q] <= 1'b0;
            ctr_q[sweep_idx_q]   <= CTR_WNT;
        end else if (wr_en) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_nxt;
                if (bus.upd_taken) tgt_q[upd_idx] <= bus.upd_target;
            end else if (bus.upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= pc_tag(bus.upd_pc);
                tgt_q[upd_idx]   <= bus.upd_target;
                ctr_q[upd_idx]   <= CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_lookups_q, stat_updates_q, stat_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q     <= '0;
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (ready)        stat_lookups_q     <= stat_lookups_q + 32'd1;
            if (wr_en)        stat_updates_q     <= stat_updates_q + 32'd1;
            if (mispredict_q) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign bus.stat_lookups     = stat_lookups_q;
    assign bus.stat_updates     = stat_updates_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; mispredict/redirect expectations go through a scoreboard queue.
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   exp_mp_pulses;

    typedef struct {
        logic        mp;
        logic [31:0] rpc;
    } mp_exp_t;

    mp_exp_t sb[$];

    branch_predictor_if bus();

    branch_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
        bus.lk_pc = pc;
        #1;
        chk({tag, ".hit"},    {31'd0, bus.lk_hit},   {31'd0, hit});
        chk({tag, ".taken"},  {31'd0, bus.lk_taken}, {31'd0, taken});
        chk({tag, ".target"}, bus.lk_target,         tgt);
    endtask

    // Expected outcome derived from the resolved/predicted values presented this cycle.
    task automatic push_exp();
        mp_exp_t e;
        e.mp  = bus.upd_en && ((bus.upd_taken != bus.upd_pred_taken) ||
                (bus.upd_taken && bus.upd_pred_target != bus.upd_target));
        e.rpc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        mp_exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed mispredict %b", tag, bus.mispredict);
        end else begin
            e = sb.pop_front();
            if (e.mp) exp_mp_pulses++;
            chk({tag, ".mispredict"}, {31'd0, bus.mispredict}, {31'd0, e.mp});
            if (e.mp) chk({tag, ".redirect_pc"}, bus.redirect_pc, e.rpc);
        end
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        bus.upd_en          = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_taken       = taken;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptaken;
        bus.upd_pred_target = ptgt;
        push_exp();
        @(posedge clk);
        #1;
        bus.upd_en = 1'b0;
        pop_chk(tag);
    endtask

    task automatic idle_cycle(input string tag);
        bus.upd_en = 1'b0;
        push_exp();
        @(posedge clk);
        #1;
        pop_chk(tag);
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_fail = 0;
        exp_mp_pulses = 0;
        rst_n = 1'b0;
        bus.lk_pc = 32'h100;
        bus.upd_en = 1'b0;
        bus.upd_pc = '0;
        bus.upd_taken = 1'b0;
        bus.upd_target = '0;
        bus.upd_pred_taken = 1'b0;
        bus.upd_pred_target = '0;
        bus.flush = 1'b0;

        #3;
        look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
        chk("reset.mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("reset.redirect_pc", bus.redirect_pc, 32'd0);
        chk("reset.ready", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        upd("alloc", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
        idle_cycle("mp_clear");

        for (int i = 0; i < 4; i++) begin
            upd("nt", 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
            look("nt", 32'h100, 1'b1, 1'b0, 32'h104);
        end
        upd("sat_up1", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        look("sat_up1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd("sat_up2", 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
        look("sat_up2", 32'h100, 1'b1, 1'b1, 32'h80);
        upd("tgt_miss", 32'h100, 1'b1, 32'h88, 1'b1, 32'h80);
        look("tgt_miss", 32'h100, 1'b1, 1'b1, 32'h88);

        // 0x200 aliases 0x100 (same index, different tag).
        bus.lk_pc = 32'h200;
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h200;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h300;
        bus.upd_pred_taken = 1'b0;
        bus.upd_pred_target = 32'h0;
        push_exp();
        #1;
        chk("same_cycle.hit", {31'd0, bus.lk_hit}, 32'd0);
        chk("same_cycle.target", bus.lk_target, 32'h204);
        @(posedge clk);
        #1;
        bus.upd_en = 1'b0;
        pop_chk("alias");
        look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);

        upd("nt_noalloc", 32'h404, 1'b0, 32'h900, 1'b0, 32'h0);
        look("nt_noalloc", 32'h404, 1'b0, 1'b0, 32'h408);
        upd("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        upd("alloc2", 32'h404, 1'b1, 32'h500, 1'b1, 32'h500);
        look("alloc2", 32'h404, 1'b1, 1'b1, 32'h500);

        bus.flush = 1'b1;
        upd("flush_upd", 32'h408, 1'b1, 32'h600, 1'b0, 32'h0);
        bus.flush = 1'b0;
        chk("flush.ready", {31'd0, bus.ready}, 32'd0);
        look("sweep_0x200", 32'h200, 1'b0, 1'b0, 32'h204);
        look("sweep_0x404", 32'h404, 1'b0, 1'b0, 32'h408);

        cnt = 0;
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h40C;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h600;
        bus.upd_pred_target = 32'h600;
        while (bus.ready === 1'b0 && cnt < 200) begin
            bus.upd_pred_taken = (cnt == 5) ? 1'b0 : 1'b1;
            push_exp();
            @(posedge clk);
            #1;
            pop_chk("sweep");
            cnt++;
        end
        bus.upd_en = 1'b0;
        chk("sweep.cycles", cnt, 32'd64);
        look("post_0x100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("post_0x200", 32'h200, 1'b0, 1'b0, 32'h204);
        look("post_0x404", 32'h404, 1'b0, 1'b0, 32'h408);
        look("post_0x408", 32'h408, 1'b0, 1'b0, 32'h40C);
        look("post_0x40C", 32'h40C, 1'b0, 1'b0, 32'h410);

        upd("realloc", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        look("realloc", 32'h100, 1'b1, 1'b1, 32'h80);
        idle_cycle("mp_clear2");

`ifdef BP_STATS_EN
        chk("stat_mispredicts", bus.stat_mispredicts, exp_mp_pulses);
`endif

        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midsweep.ready", {31'd0, bus.ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_midsweep.ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_midsweep.mispredict", {31'd0, bus.mispredict}, 32'd0);
        look("rst_midsweep", 32'h100, 1'b0, 1'b0, 32'h104);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
